// File: rtl/beat_sequencer.sv
// Tempo-driven drum step sequencer: a programmable tick divider walks a STEPS-long
// pattern and emits registered one-cycle trigger pulses per channel on every step.
module beat_sequencer #(
  parameter int BITLEN   = 8,
  parameter int STEPS    = 8,
  parameter int CHANNELS = 4,
  parameter logic [BITLEN-1:0] LIM_RST = 8'd99,
  localparam int SW = $clog2(STEPS),
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITLEN-1:0]   lim_in,
  input  logic                lim_load,
  input  logic                start,
  input  logic                stop,
  input  logic                pat_we,
  input  logic [CW-1:0]       pat_ch,
  input  logic [SW-1:0]       pat_step,
  input  logic                pat_val,
  output logic [CHANNELS-1:0] trig,
  output logic                beat,
  output logic [SW-1:0]       step,
  output logic                running
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                             state_q, state_d;
  logic [BITLEN-1:0]                  lim_q, lim_d;
  logic [BITLEN-1:0]                  cnt_q, cnt_d;
  logic [SW-1:0]                      step_q, step_d;
  logic [CHANNELS-1:0][STEPS-1:0]     pattern_q, pattern_d;
  logic                               fire_q, fire_d;
  logic [CHANNELS-1:0]                trig_q, trig_d;
  logic                               beat_q, beat_d;
  logic                               running_q, running_d;
  logic                               tick;

  always_comb begin
    tick      = (state_q == RUN) && (cnt_q >= lim_q);
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    fire_d    = 1'b0;
    lim_d     = lim_load ? lim_in : lim_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !stop) begin
          state_d = RUN;
          step_d  = '0;
          fire_d  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          step_d  = '0;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d  = '0;
          step_d = step_q + 1'b1;
          fire_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN);

    // A fire samples the pattern before any write in the same cycle lands.
    for (int c = 0; c < CHANNELS; c++) begin
      trig_d[c] = fire_q & pattern_q[c][step_q];
    end
    beat_d = fire_q && (step_q == '0);

    pattern_d = pattern_q;
    if (pat_we && (int'(pat_ch) < CHANNELS)) begin
      pattern_d[pat_ch][pat_step] = pat_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lim_q     <= LIM_RST;
      cnt_q     <= '0;
      step_q    <= '0;
      pattern_q <= '0;
      fire_q    <= 1'b0;
      trig_q    <= '0;
      beat_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lim_q     <= lim_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      pattern_q <= pattern_d;
      fire_q    <= fire_d;
      trig_q    <= trig_d;
      beat_q    <= beat_d;
      running_q <= running_d;
    end
  end

  assign trig    = trig_q;
  assign beat    = beat_q;
  assign step    = step_q;
  assign running = running_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer: stimulus pushes expected trigger pulses
// stamped with their edge number, and a negedge monitor pops and compares them.
module tb_beat_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lim_in;
  logic       lim_load, start, stop, pat_we, pat_val;
  logic [1:0] pat_ch;
  logic [2:0] pat_step;
  logic [3:0] trig;
  logic       beat;
  logic [2:0] step;
  logic       running;

  typedef struct {
    int         cyc;
    logic [3:0] trig;
    logic       beat;
  } pulse_t;

  pulse_t     exp_q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [3:0] mcol [8];

  beat_sequencer dut (
    .clk(clk), .rst(rst), .lim_in(lim_in), .lim_load(lim_load),
    .start(start), .stop(stop), .pat_we(pat_we), .pat_ch(pat_ch),
    .pat_step(pat_step), .pat_val(pat_val), .trig(trig), .beat(beat),
    .step(step), .running(running)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Monitor: every pulse on trig/beat must match the oldest expected entry.
  initial begin
    pulse_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missed pulse: got none at edge %0d, expected trig=%b beat=%b", e.cyc, e.trig, e.beat);
      end
      if (trig != 4'b0 || beat) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected pulse @%0d: got trig=%b beat=%b, expected none", cyc, trig, beat);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.trig != trig || e.beat != beat) begin
            errors++;
            $display("[TB] FAIL pulse: got @%0d trig=%b beat=%b, expected @%0d trig=%b beat=%b",
                     cyc, trig, beat, e.cyc, e.trig, e.beat);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tickCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitEdge(input int e);
    while (cyc < e) tickCycle();
  endtask

  task automatic pushPulse(input int c, input logic [3:0] tr, input logic b);
    pulse_t p;
    p.cyc  = c;
    p.trig = tr;
    p.beat = b;
    exp_q.push_back(p);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s @%0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp);
    start = st;
    stop  = sp;
    tickCycle();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic writePat(input int c, input int s, input logic v);
    pat_we   = 1'b1;
    pat_ch   = 2'(c);
    pat_step = 3'(s);
    pat_val  = v;
    tickCycle();
    pat_we   = 1'b0;
    mcol[s][c] = v;
  endtask

  task automatic loadLim(input logic [7:0] v);
    lim_load = 1'b1;
    lim_in   = v;
    tickCycle();
    lim_load = 1'b0;
  endtask

  task automatic startPlay(input int lim, input int n, output int t);
    int s;
    applyStimulus(1'b1, 1'b0);
    t = cyc;
    for (int k = 0; k < n; k++) begin
      s = k % 8;
      if (mcol[s] != 4'b0 || s == 0) pushPulse(t + 1 + k * (lim + 1), mcol[s], s == 0);
    end
    checkOutput("running after start", int'(running), 1);
    checkOutput("step after start", int'(step), 0);
  endtask

  task automatic stopPlay(input int t, input int lim, input int n);
    waitEdge(t + (n - 1) * (lim + 1));
    applyStimulus(1'b0, 1'b1);
    checkOutput("running after stop", int'(running), 0);
    checkOutput("step after stop", int'(step), 0);
  endtask

  initial begin
    int t;
    for (int s = 0; s < 8; s++) mcol[s] = 4'b0;
    rst = 1'b1; lim_in = 8'd0; lim_load = 1'b0; start = 1'b0; stop = 1'b0;
    pat_we = 1'b0; pat_ch = 2'd0; pat_step = 3'd0; pat_val = 1'b0;
    tickCycle();
    tickCycle();
    rst = 1'b0;

    // Reset state and idle behaviour
    repeat (20) tickCycle();
    checkOutput("reset trig", int'(trig), 0);
    checkOutput("reset beat", int'(beat), 0);
    checkOutput("reset running", int'(running), 0);
    checkOutput("reset step", int'(step), 0);

    // Default limit 99: 100-cycle step period, beat even with empty pattern
    startPlay(99, 2, t);
    waitEdge(t + 99);
    checkOutput("lim99 step before tick", int'(step), 0);
    waitEdge(t + 100);
    checkOutput("lim99 step after tick", int'(step), 1);
    stopPlay(t, 99, 2);

    // Limit 3 with ch0 on steps 0/4, ch1 on all steps, wrap after step 7
    loadLim(8'd3);
    writePat(0, 0, 1'b1);
    writePat(0, 4, 1'b1);
    for (int s = 0; s < 8; s++) writePat(1, s, 1'b1);
    startPlay(3, 9, t);
    waitEdge(t + 3);
    checkOutput("lim3 step held", int'(step), 0);
    waitEdge(t + 4);
    checkOutput("lim3 step 1", int'(step), 1);
    waitEdge(t + 28);
    checkOutput("lim3 step 7", int'(step), 7);
    waitEdge(t + 32);
    checkOutput("lim3 wrap step", int'(step), 0);
    stopPlay(t, 3, 9);

    // Limit 0: a step every cycle; stop coincides with a tick and wins
    loadLim(8'd0);
    for (int s = 0; s < 8; s++) writePat(2, s, 1'b1);
    startPlay(0, 4, t);
    waitEdge(t + 1);
    checkOutput("lim0 step 1", int'(step), 1);
    waitEdge(t + 2);
    checkOutput("lim0 step 2", int'(step), 2);
    waitEdge(t + 3);
    checkOutput("lim0 step 3", int'(step), 3);
    stopPlay(t, 0, 4);

    // Lowering the limit below the current count ticks on the next cycle
    loadLim(8'd10);
    applyStimulus(1'b1, 1'b0);
    t = cyc;
    pushPulse(t + 1,  4'b0111, 1'b1);
    pushPulse(t + 10, 4'b0110, 1'b0);
    pushPulse(t + 13, 4'b0110, 1'b0);
    pushPulse(t + 16, 4'b0110, 1'b0);
    waitEdge(t + 7);
    loadLim(8'd2);
    checkOutput("lower lim no tick yet", int'(step), 0);
    waitEdge(t + 9);
    checkOutput("lower lim early tick", int'(step), 1);
    waitEdge(t + 12);
    checkOutput("lower lim period a", int'(step), 2);
    waitEdge(t + 15);
    checkOutput("lower lim period b", int'(step), 3);
    applyStimulus(1'b0, 1'b1);
    checkOutput("stop running", int'(running), 0);

    // start and stop together in IDLE: stop wins
    applyStimulus(1'b1, 1'b1);
    checkOutput("start+stop running", int'(running), 0);
    tickCycle();
    checkOutput("start+stop step", int'(step), 0);

    // Reset while a step-0 fire is pending: nothing emerges
    loadLim(8'd3);
    applyStimulus(1'b1, 1'b0);
    rst = 1'b1;
    tickCycle();
    rst = 1'b0;
    checkOutput("rst trig", int'(trig), 0);
    checkOutput("rst beat", int'(beat), 0);
    checkOutput("rst running", int'(running), 0);
    checkOutput("rst step", int'(step), 0);
    for (int s = 0; s < 8; s++) mcol[s] = 4'b0;

    // After reset: pattern cleared (beat only) and limit back to 99
    applyStimulus(1'b1, 1'b0);
    t = cyc;
    pushPulse(t + 1, 4'b0000, 1'b1);
    waitEdge(t + 4);
    checkOutput("rst restores limit", int'(step), 0);
    applyStimulus(1'b0, 1'b1);

    // Pattern write in the cycle step 3 fires uses the old value
    loadLim(8'd1);
    applyStimulus(1'b1, 1'b0);
    t = cyc;
    pushPulse(t + 1,  4'b0000, 1'b1);
    pushPulse(t + 17, 4'b0000, 1'b1);
    pushPulse(t + 23, 4'b0010, 1'b0);
    waitEdge(t + 6);
    checkOutput("write race step", int'(step), 3);
    writePat(1, 3, 1'b1);
    waitEdge(t + 22);
    checkOutput("second pass step", int'(step), 3);
    applyStimulus(1'b0, 1'b1);

    repeat (5) tickCycle();
    checkOutput("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Tempo-driven step sequencer for the drum machine. It owns a programmable tick divider, in the same style as the design's clock dividers. It walks a STEPS-long pattern for CHANNELS drum voices and emits one-cycle trigger pulses per channel on each step. Downstream voice generators consume it; the user-input/config logic controls tempo, start/stop and pattern edits.

## Interface
- BITLEN, 8: width of tempo limit and tick counter
- STEPS, 8: pattern length; power of two, ≥2
- CHANNELS, 4: number of drum voices, ≥1
- LIM_RST, 8'd99: tempo limit value after reset
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- lim_in  input  BITLEN  new tempo limit
- lim_load  input  1  load lim_in into limit register
- start  input  1  start playback, one-cycle pulse or level
- stop  input  1  stop playback
- pat_we  input  1  pattern write enable
- pat_ch  input  $clog2(CHANNELS) (min 1)  channel to write
- pat_step  input  $clog2(STEPS)  step to write
- pat_val  input  1  bit value written
- trig  output  CHANNELS  per-channel one-cycle trigger
- beat  output  1  one-cycle pulse coincident with step-0 triggers
- step  output  $clog2(STEPS)  step currently playing
- running  output  1  high in RUN state

## Operation
- Registers:
  - lim_r (BITLEN): tempo limit.
  - Q (BITLEN): tick counter.
  - step_r: current step.
  - pattern: CHANNELS×STEPS bits.
  - state: IDLE or RUN.
- Reset values: lim_r=LIM_RST, Q=0, step=0, pattern all 0, state=IDLE, trig=0, beat=0, running=0.
- Tick: asserted combinationally when state=RUN and Q ≥ lim_r.
  - On a tick, Q←0; otherwise in RUN, Q←Q+1.
  - In IDLE, Q is held at 0.
  - The ≥ compare ensures a lowered limit never causes a full BITLEN wrap.
- Step period is lim_r+1 cycles; lim_r=0 gives a step every cycle.
- State transitions:
  - IDLE, start=1, stop=0 → RUN. Step←0, Q←0, and a "fire" of step 0 is issued.
  - RUN, tick → step←(step+1) mod STEPS, and a fire of the new step is issued.
  - RUN, stop=1 → IDLE. Step←0, Q←0, no fire.
  - start in RUN is ignored.
  - stop in IDLE is ignored.
  - start and stop in the same cycle: stop wins; from IDLE, stay IDLE.
- Fire of step s: on the next edge, trig[c]←pattern[c][s] for every c, and beat←(s==0). Otherwise trig=0 and beat=0. Trig bits and beat are registered, single-cycle pulses.
- A channel whose pattern bit is 0 produces no pulse. beat pulses on step 0 even if every pattern bit is 0.
- lim_load: lim_r←lim_in on the next edge, in any state. The new limit applies to the compare from the following cycle; the current Q is not cleared.
- Pattern write: when pat_we=1, pattern[pat_ch][pat_step]←pat_val.
  - Out-of-range pat_ch (CHANNELS not a power of two) is ignored.
  - A fire of the same cell in the same cycle uses the old value; the new value is visible to fires issued on later cycles.
- running = (state==RUN), registered.
- step output equals step_r.
- rst mid-run returns everything to reset values on that edge. trig and beat are 0 on the cycle after rst.

## Timing
- Start sampled at edge t:
  - running=1 and step=0 after edge t.
  - Step-0 trig/beat high during cycle t+1 → t+2.
- Step k (k<STEPS) trig is high one cycle, starting at edge t+1+k·(lim_r+1), with lim_r constant.
- Step output changes on the same edge that the tick is sampled, i.e. one cycle before the matching trig pulse.
- Wrap: after step STEPS-1, the next tick gives step=0, beat=1, and the step-0 trig pattern again.
- Stop sampled at edge u: running=0 and step=0 after edge u. No trig after edge u+1. A pulse already registered at edge u (from a tick in cycle u-1) still appears, because stop does not cancel it.
- Latency from lim_load to the affected compare: 1 cycle.

## Test plan
- Reset, then idle for 20 cycles. Expect trig=0, beat=0, running=0, step=0, and lim_r=99 (verify via period after start).
- lim_load lim_in=3, pattern ch0 = step 0 and 4, ch1 = all steps, then start at edge t. Expect trig=2'b11 at t+1 and beat=1, trig[1] every 4 cycles, trig[0] at t+1 and t+17, and wrap to step 0 at t+33 with beat=1.
- lim_in=0, 4 steps played, pattern ch2 all ones. Expect trig[2] high continuously for consecutive cycles (one pulse per step) and step incrementing every cycle.
- While running at lim=10 with Q=7, load lim=2. Expect a tick the next cycle via the ≥ compare, then a 3-cycle period.
- Assert start and stop together in IDLE: expect state to stay IDLE. Then stop mid-run: expect step=0, running=0, and no further trig. Then issue rst in RUN: expect all outputs 0 on the next cycle and the pattern cleared.
- Write pattern[1][3]=1 in the same cycle that step 3 fires: expect trig[1]=0 at that step, and expect trig[1]=1 at step 3 on the next pass.
